// File: rtl/serial_addsub_pkg.sv
// serial_addsub_pkg
//   Shared types and elaboration-time helpers for the serial adder/subtractor.
//   - state_t        : FSM encoding {IDLE, RUN, DONE}, 2 bits
//   - calc_n()       : steps per operation, N = WIDTH/BPC
//   - cnt_w()        : step counter width, clog2(N) with a floor of 1
//   - max_pos()      : 0111..1 for a given WIDTH (low WIDTH bits meaningful)
//   - min_neg()      : 1000..0 for a given WIDTH (low WIDTH bits meaningful)
package serial_addsub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int calc_n(input int width, input int bpc);
    return width / bpc;
  endfunction

  function automatic int cnt_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  function automatic logic [63:0] max_pos(input int width);
    logic [63:0] v;
    v = '0;
    for (int i = 0; i < width - 1; i++) v[i] = 1'b1;
    return v;
  endfunction

  function automatic logic [63:0] min_neg(input int width);
    logic [63:0] v;
    v = '0;
    v[width-1] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/serial_addsub_full_adder_bit.sv
// full_adder_bit
//   Combinational 1-bit full adder, one link of the ripple chain.
//   Ports: x, y (addend bits), ci (carry in) -> s (sum), co (carry out)
module full_adder_bit (
  input  logic x,
  input  logic y,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = x ^ y ^ ci;
  assign co = (x & y) | (ci & (x ^ y));
endmodule

// File: rtl/serial_addsub.sv
// serial_addsub
//   Multi-cycle adder/subtractor: BPC bits per clock, LSBs first, carry held
//   in a register between steps. start/busy/done handshake.
//   Optional macro SERIAL_ADDSUB_SATURATE_EN: saturate result on signed overflow.
//   Ports:
//     clk, rst        clock, asynchronous active-high reset
//     start           request an operation (sampled only in IDLE)
//     sub             0 = a+b, 1 = a-b (captured with start)
//     a, b            WIDTH-bit operands (captured with start)
//     busy            high in RUN and DONE
//     done            one-cycle pulse, result/flags valid
//     result          sum/difference modulo 2^WIDTH
//     cout            carry out of MSB (subtraction: 1 = no borrow)
//     ovf             two's-complement overflow
//     zero            result == 0
module serial_addsub
  import serial_addsub_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int BPC   = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  localparam int N  = calc_n(WIDTH, BPC);
  localparam int CW = cnt_w(N);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  generate
    if (WIDTH < 2 || (WIDTH % BPC) != 0 || BPC < 1) begin : g_bad_cfg
      $error("serial_addsub: WIDTH must be >= 2 and a multiple of BPC");
    end
  endgenerate

  state_t           r_state;
  logic [WIDTH-1:0] r_opa, r_opb, r_acc;
  logic             r_carry;
  logic [CW-1:0]    r_step;
  logic [WIDTH-1:0] r_result;
  logic             r_cout, r_ovf, r_zero, r_busy, r_done;

  // Ripple chain over the low BPC bits of the shifting operands.
  logic [BPC:0]     w_c;
  logic [BPC-1:0]   w_s;
  logic [WIDTH-1:0] w_acc_nxt;
  logic [WIDTH-1:0] w_res_final;
  logic             w_ovf;

  assign w_c[0] = r_carry;

  genvar gi;
  generate
    for (gi = 0; gi < BPC; gi++) begin : g_chain
      full_adder_bit u_fa (
        .x  (r_opa[gi]),
        .y  (r_opb[gi]),
        .ci (w_c[gi]),
        .s  (w_s[gi]),
        .co (w_c[gi+1])
      );
    end

    // New sum bits enter at the MSB end; after N steps the first chunk has
    // travelled down to bit 0.
    if (BPC == WIDTH) begin : g_acc_full
      assign w_acc_nxt = w_s;
    end else begin : g_acc_shift
      assign w_acc_nxt = {w_s, r_acc[WIDTH-1:BPC]};
    end
  endgenerate

  // On the final step the chain's top link is the operand MSB.
  assign w_ovf = w_c[BPC-1] ^ w_c[BPC];

`ifdef SERIAL_ADDSUB_SATURATE_EN
  localparam logic [63:0] MAX_POS_L = max_pos(WIDTH);
  localparam logic [63:0] MIN_NEG_L = min_neg(WIDTH);
  localparam logic [WIDTH-1:0] MAX_POS = MAX_POS_L[WIDTH-1:0];
  localparam logic [WIDTH-1:0] MIN_NEG = MIN_NEG_L[WIDTH-1:0];

  logic r_amsb;  // sign of captured a picks the saturation direction

  assign w_res_final = w_ovf ? (r_amsb ? MIN_NEG : MAX_POS) : w_acc_nxt;
`else
  assign w_res_final = w_acc_nxt;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= IDLE;
      r_opa    <= '0;
      r_opb    <= '0;
      r_acc    <= '0;
      r_carry  <= 1'b0;
      r_step   <= '0;
      r_result <= '0;
      r_cout   <= 1'b0;
      r_ovf    <= 1'b0;
      r_zero   <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
`ifdef SERIAL_ADDSUB_SATURATE_EN
      r_amsb   <= 1'b0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          r_done <= 1'b0;
          if (start) begin
            r_opa   <= a;
            r_opb   <= sub ? ~b : b;  // a-b = a + ~b + 1
            r_carry <= sub;
            r_step  <= '0;
            r_acc   <= '0;
            r_busy  <= 1'b1;
`ifdef SERIAL_ADDSUB_SATURATE_EN
            r_amsb  <= a[WIDTH-1];
`endif
            r_state <= RUN;
          end
        end
        RUN: begin
          r_acc   <= w_acc_nxt;
          r_opa   <= r_opa >> BPC;
          r_opb   <= r_opb >> BPC;
          r_carry <= w_c[BPC];
          r_step  <= r_step + CW'(1);
          if (r_step == LAST) begin
            r_result <= w_res_final;
            r_cout   <= w_c[BPC];
            r_ovf    <= w_ovf;
            r_zero   <= (w_res_final == '0);
            r_done   <= 1'b1;
            r_state  <= DONE;
          end
        end
        DONE: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign busy   = r_busy;
  assign done   = r_done;
  assign result = r_result;
  assign cout   = r_cout;
  assign ovf    = r_ovf;
  assign zero   = r_zero;

endmodule

// File: tb/tb_serial_addsub.sv
module tb_serial_addsub;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // dut0: WIDTH=8, BPC=1 (N=8); dut4: WIDTH=8, BPC=4 (N=2)
  logic       st0, sb0, bsy0, dn0, c0, o0, z0;
  logic [7:0] a0, b0, r0;
  logic       st4, sb4, bsy4, dn4, c4, o4, z4;
  logic [7:0] a4, b4, r4;

  serial_addsub #(.WIDTH(8), .BPC(1)) dut0 (
    .clk(clk), .rst(rst), .start(st0), .sub(sb0), .a(a0), .b(b0),
    .busy(bsy0), .done(dn0), .result(r0), .cout(c0), .ovf(o0), .zero(z0));

  serial_addsub #(.WIDTH(8), .BPC(4)) dut4 (
    .clk(clk), .rst(rst), .start(st4), .sub(sb4), .a(a4), .b(b4),
    .busy(bsy4), .done(dn4), .result(r4), .cout(c4), .ovf(o4), .zero(z4));

  int npass = 0;
  int ntot  = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    ntot++;
    if (act === exp) npass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
  endtask

  // Reference: packs {result[7:0], cout, ovf, zero}, computed from signed
  // and unsigned integer arithmetic rather than a bit-level carry chain.
  function automatic logic [10:0] model(input logic [7:0] a, input logic [7:0] b, input logic s);
    int ua, ub, sa, sb, ideal, usum;
    logic [7:0] r;
    logic c, o;
    ua = int'(a); ub = int'(b);
    sa = (ua > 127) ? ua - 256 : ua;
    sb = (ub > 127) ? ub - 256 : ub;
    ideal = s ? sa - sb : sa + sb;
    usum  = s ? ua - ub : ua + ub;
    c = s ? (ua >= ub) : (usum > 255);
    o = (ideal > 127) || (ideal < -128);
    r = 8'((usum % 256 + 256) % 256);
`ifdef SERIAL_ADDSUB_SATURATE_EN
    if (o) r = (ideal > 127) ? 8'h7F : 8'h80;
`endif
    return {r, c, o, (r == 8'h00)};
  endfunction

  // One full operation on the selected DUT. lat = rising edges from the
  // start edge until done is seen; bcnt = busy-high cycles; post = {busy,done}
  // one cycle after done; held = result observed during RUN.
  task automatic run_op(input int sel, input logic [7:0] a, input logic [7:0] b, input logic s,
                        output logic [10:0] got, output int lat, output int bcnt,
                        output logic [1:0] post, output logic [7:0] held, output bit to);
    to = 0; lat = 0; bcnt = 0;
    @(negedge clk);
    if (sel == 0) begin a0 = a; b0 = b; sb0 = s; st0 = 1'b1; end
    else          begin a4 = a; b4 = b; sb4 = s; st4 = 1'b1; end
    @(posedge clk);
    @(negedge clk);
    // scramble inputs: result must depend on captured values only
    if (sel == 0) begin st0 = 1'b0; a0 = 8'($urandom); b0 = 8'($urandom); sb0 = ~s; end
    else          begin st4 = 1'b0; a4 = 8'($urandom); b4 = 8'($urandom); sb4 = ~s; end
    held = (sel == 0) ? r0 : r4;
    for (int k = 0; k < 40; k++) begin
      if ((sel == 0) ? bsy0 : bsy4) bcnt++;
      if ((sel == 0) ? dn0 : dn4) break;
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (k == 39) to = 1;
    end
    got  = (sel == 0) ? {r0, c0, o0, z0} : {r4, c4, o4, z4};
    @(negedge clk);
    post = (sel == 0) ? {bsy0, dn0} : {bsy4, dn4};
  endtask

  typedef struct {
    logic [7:0] a, b;
    logic       s;
    logic [7:0] er;
    logic       ec, eo, ez;
  } vec_t;

  vec_t vt[8];

  initial begin
    logic [10:0] got, exp;
    logic [1:0]  post;
    logic [7:0]  held, prev, ra, rb;
    logic        rs;
    int lat, bcnt, ndone, e;
    bit to;

    vt[0] = '{8'h05, 8'h03, 1'b0, 8'h08, 1'b0, 1'b0, 1'b0};
`ifdef SERIAL_ADDSUB_SATURATE_EN
    vt[1] = '{8'h7F, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1, 1'b0};
    vt[4] = '{8'h80, 8'h01, 1'b1, 8'h80, 1'b1, 1'b1, 1'b0};
    vt[6] = '{8'h80, 8'h80, 1'b0, 8'h80, 1'b1, 1'b1, 1'b0};
`else
    vt[1] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1, 1'b0};
    vt[4] = '{8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b1, 1'b0};
    vt[6] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1};
`endif
    vt[2] = '{8'h03, 8'h05, 1'b1, 8'hFE, 1'b0, 1'b0, 1'b0};
    vt[3] = '{8'h05, 8'h05, 1'b1, 8'h00, 1'b1, 1'b0, 1'b1};
    vt[5] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1};
    vt[7] = '{8'h00, 8'h00, 1'b1, 8'h00, 1'b1, 1'b0, 1'b1};

    rst = 1'b1;
    st0 = 0; sb0 = 0; a0 = 0; b0 = 0;
    st4 = 0; sb4 = 0; a4 = 0; b4 = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_dut0", {bsy0, dn0, r0, c0, o0, z0}, 0);
    check("reset_dut4", {bsy4, dn4, r4, c4, o4, z4}, 0);
    rst = 1'b0;

    // Directed table on BPC=1
    prev = 8'h00;
    for (int i = 0; i < 8; i++) begin
      run_op(0, vt[i].a, vt[i].b, vt[i].s, got, lat, bcnt, post, held, to);
      check("timeout", 32'(to), 0);
      check($sformatf("vec%0d_result", i), 32'(got[10:3]), 32'(vt[i].er));
      check($sformatf("vec%0d_flags", i), 32'(got[2:0]), 32'({vt[i].ec, vt[i].eo, vt[i].ez}));
      check($sformatf("vec%0d_latency", i), lat, 8);
      check($sformatf("vec%0d_busy_cycles", i), bcnt, 9);
      check($sformatf("vec%0d_post_done", i), 32'(post), 0);
      check($sformatf("vec%0d_result_held", i), 32'(held), 32'(prev));
      prev = got[10:3];
    end

    // BPC=4, N=2
    run_op(1, 8'hFF, 8'h01, 1'b0, got, lat, bcnt, post, held, to);
    check("bpc4_timeout", 32'(to), 0);
    check("bpc4_out", 32'(got), 32'({8'h00, 1'b1, 1'b0, 1'b1}));
    check("bpc4_latency", lat, 2);
    check("bpc4_busy_cycles", bcnt, 3);
    check("bpc4_post_done", 32'(post), 0);

    // Random against the model
    for (int i = 0; i < 40; i++) begin
      ra = 8'($urandom); rb = 8'($urandom); rs = 1'($urandom);
      exp = model(ra, rb, rs);
      run_op(i % 4 == 0 ? 1 : 0, ra, rb, rs, got, lat, bcnt, post, held, to);
      check($sformatf("rand%0d a=%0h b=%0h s=%0d", i, ra, rb, rs), 32'(got), 32'(exp));
    end

    // start pulsed 3 cycles into RUN is ignored
    @(negedge clk); a0 = 8'h11; b0 = 8'h22; sb0 = 0; st0 = 1;
    @(posedge clk);
    @(negedge clk); st0 = 0;
    repeat (3) @(posedge clk);
    @(negedge clk); st0 = 1; a0 = 8'hFF; b0 = 8'hFF; sb0 = 1;
    @(posedge clk);
    @(negedge clk); st0 = 0;
    ndone = 0; held = 8'h00;
    for (int k = 0; k < 30; k++) begin
      if (dn0) begin ndone++; held = r0; end
      @(negedge clk);
    end
    check("ignored_start_done_count", ndone, 1);
    check("ignored_start_result", 32'(held), 32'h33);

    // start held high: back-to-back ops, N+2 cycles apart
    @(negedge clk); a0 = 8'h10; b0 = 8'h20; sb0 = 1; st0 = 1;
    to = 1;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (dn0) begin to = 0; break; end
    end
    check("held_start_first_done", 32'(to), 0);
    e = 0; to = 1;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); e++;
      @(negedge clk);
      if (dn0) begin to = 0; break; end
    end
    st0 = 0;
    check("held_start_second_done", 32'(to), 0);
    check("held_start_spacing", e, 10);
    check("held_start_result", 32'({r0, c0, o0, z0}), 32'({8'hF0, 1'b0, 1'b0, 1'b0}));

    // reset mid-RUN at step 4
    @(negedge clk); a0 = 8'h7F; b0 = 8'h01; sb0 = 0; st0 = 1;
    @(posedge clk);
    @(negedge clk); st0 = 0;
    repeat (4) @(posedge clk);
    #1 rst = 1'b1;
    #1 check("midrun_reset_outputs", {bsy0, dn0, r0, c0, o0, z0}, 0);
    @(negedge clk); rst = 1'b0;
    ndone = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (dn0 || bsy0) ndone++;
    end
    check("midrun_reset_no_done", ndone, 0);

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
